// File: rtl/instr_encoder.sv
// instr_encoder: packs register/function fields and a sign-extended immediate
// into an RV32 instruction word. Illegal requests become a NOP with an error
// flag. Words are queued in a 2-entry FIFO and tagged with a write address.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready depends only on fill)
//   imm_type              000 I, 001 S, 010 B, 011 J, 100 U, 101 R, else illegal
//   opcode, rd, funct3, rs1, rs2, funct7, imm   instruction fields
//   out_valid / out_ready head-word handshake
//   out_instr, out_err    head word and its illegal-request flag (0 when empty)
//   out_addr              write address of the head word
//   err_cnt               saturating count of accepted illegal requests
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           imm_type,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [2:0]           funct3,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [6:0]           funct7,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [31:0]          out_addr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IT_I = 3'b000,
    IT_S = 3'b001,
    IT_B = 3'b010,
    IT_J = 3'b011,
    IT_U = 3'b100,
    IT_R = 3'b101
  } imm_type_e;

  logic [31:0]          w_enc;
  logic                 w_legal;
  logic [31:0]          w_word;
  logic                 w_push;
  logic                 w_pop;

  // Slot 0 is always the head; it is held at zero while the queue is empty
  // so out_instr/out_err come straight from registers.
  logic [31:0]          r_instr0;
  logic                 r_err0;
  logic [31:0]          r_instr1;
  logic                 r_err1;
  logic [1:0]           r_count;
  logic [31:0]          r_addr;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Field packing and immediate range check
  always_comb begin
    w_enc   = NOP;
    w_legal = 1'b0;
    case (imm_type)
      IT_I: begin
        w_enc   = {imm[11:0], rs1, funct3, rd, opcode};
        w_legal = (&imm[31:11]) | ~(|imm[31:11]);
      end
      IT_S: begin
        w_enc   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        w_legal = (&imm[31:11]) | ~(|imm[31:11]);
      end
      IT_B: begin
        w_enc   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        w_legal = ~imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
      end
      IT_J: begin
        w_enc   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        w_legal = ~imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));
      end
      IT_U: begin
        w_enc   = {imm[31:12], rd, opcode};
        w_legal = ~(|imm[11:0]);
      end
      IT_R: begin
        w_enc   = {funct7, rs2, rs1, funct3, rd, opcode};
        w_legal = 1'b1;
      end
      default: begin
        w_enc   = NOP;
        w_legal = 1'b0;
      end
    endcase
    w_word = w_legal ? w_enc : NOP;
  end

  assign in_ready  = (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_instr = r_instr0;
  assign out_err   = r_err0;
  assign out_addr  = r_addr;
  assign err_cnt   = r_err_cnt;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_ready & out_valid;

  // Two-entry queue with shift-to-head on pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr0 <= 32'd0;
      r_err0   <= 1'b0;
      r_instr1 <= 32'd0;
      r_err1   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_instr0 <= w_word;
            r_err0   <= ~w_legal;
            r_count  <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_instr0 <= w_word;
            r_err0   <= ~w_legal;
          end else if (w_push) begin
            r_instr1 <= w_word;
            r_err1   <= ~w_legal;
            r_count  <= 2'd2;
          end else if (w_pop) begin
            r_instr0 <= 32'd0;
            r_err0   <= 1'b0;
            r_count  <= 2'd0;
          end
        end
        2'd2: begin
          // in_ready is low here, so only a pop can happen
          if (w_pop) begin
            r_instr0 <= r_instr1;
            r_err0   <= r_err1;
            r_instr1 <= 32'd0;
            r_err1   <= 1'b0;
            r_count  <= 2'd1;
          end
        end
        default: begin
          r_instr0 <= 32'd0;
          r_err0   <= 1'b0;
          r_count  <= 2'd0;
        end
      endcase
    end
  end

  // Head write address advances by one word per pop, wrapping naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= BASE_ADDR;
    end else if (w_pop) begin
      r_addr <= r_addr + 32'd4;
    end
  end

  // Saturating illegal-request counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_push && !w_legal && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule
